// File: rtl/fetch_pkg.sv
// fetch_pkg: shared FSM state type and fetch width constants.
package fetch_pkg;
  typedef enum logic [2:0] {IDLE, REQ, WAIT, PUSH, DROP} state_t;
  localparam int ILEN = 32;
  localparam int PC_INC = ILEN / 8;
endpackage

// File: rtl/fetch_pc.sv
// fetch_pc: program counter register with reset/redirect/increment next-PC mux.
module fetch_pc import fetch_pkg::*; #(
  parameter int XLEN = ILEN,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            inc,
  input  logic            redirect,
  input  logic [XLEN-1:0] target,
  output logic [XLEN-1:0] pc
);
  localparam logic [XLEN-1:0] STEP = XLEN'(PC_INC * XLEN / ILEN);
  logic [XLEN-1:0] pc_next;
  always_comb pc_next = rst ? RESET_PC : redirect ? target : inc ? pc + STEP : pc;
  always_ff @(posedge clk) pc <= pc_next;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: single-outstanding instruction fetcher feeding a ring buffer.
// Define FETCH_MISALIGN_EN to flag misaligned redirects instead of masking them.
module fetch_unit import fetch_pkg::*; #(
  parameter int XLEN = ILEN,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  output logic              o_imem_req,
  output logic [XLEN-1:0]   o_imem_addr,
  input  logic              i_imem_ack,
  input  logic [XLEN-1:0]   i_imem_rdata,
  output logic [2*XLEN-1:0] o_data,
  output logic              o_we,
  input  logic              i_full,
  input  logic              i_redirect,
  input  logic [XLEN-1:0]   i_redirect_pc
`ifdef FETCH_MISALIGN_EN
  ,
  output logic              o_misalign
`endif
);
  state_t state, state_next;
  logic [XLEN-1:0] pc, hold, target;
  logic inc, bad, parked;
`ifdef FETCH_MISALIGN_EN
  assign bad = i_redirect && (i_redirect_pc[1:0] != 2'b00);
  assign target = i_redirect_pc;
  // parked: a misaligned redirect left us in IDLE until an aligned one arrives
  always_ff @(posedge i_clk) begin
    parked <= i_rst ? 1'b0 : i_redirect ? bad : parked;
    o_misalign <= i_rst ? 1'b0 : bad;
  end
`else
  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);
  assign bad = 1'b0;
  assign parked = 1'b0;
  assign target = i_redirect_pc & ALIGN_MASK;
`endif
  fetch_pc #(.XLEN(XLEN), .RESET_PC(RESET_PC)) u_pc (
    .clk(i_clk),
    .rst(i_rst),
    .inc(inc),
    .redirect(i_redirect),
    .target(target),
    .pc(pc)
  );
  always_comb begin
    state_next = state;
    inc = 1'b0;
    case (state)
      IDLE: state_next = (!parked || i_redirect) ? REQ : IDLE;
      REQ:  state_next = i_redirect ? DROP : WAIT;
      WAIT: state_next = i_imem_ack ? (i_redirect ? REQ : PUSH) : (i_redirect ? DROP : WAIT);
      PUSH: begin
        state_next = (i_redirect || !i_full) ? REQ : PUSH;
        inc = !i_redirect && !i_full;
      end
      DROP: state_next = i_imem_ack ? REQ : DROP;
      default: state_next = IDLE;
    endcase
    if (bad) begin
      state_next = IDLE;
      inc = 1'b0;
    end
  end
  always_ff @(posedge i_clk) begin
    state <= i_rst ? IDLE : state_next;
    hold <= i_rst ? '0 : (state == WAIT && i_imem_ack) ? i_imem_rdata : hold;
  end
  assign o_imem_req  = !i_rst && state == REQ;
  assign o_imem_addr = pc;
  assign o_we        = !i_rst && state == PUSH && !i_redirect && !i_full;
  assign o_data      = (!i_rst && state == PUSH) ? {pc, hold} : '0;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed checks of fetch_unit against a latency-programmable memory model.
module tb_fetch_unit;
  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        i_imem_ack = 1'b0;
  logic [31:0] i_imem_rdata = '0;
  logic [63:0] o_data;
  logic        o_we;
  logic        i_full = 1'b0;
  logic        i_redirect = 1'b0;
  logic [31:0] i_redirect_pc = '0;
`ifdef FETCH_MISALIGN_EN
  logic        o_misalign;
`endif
  int vec = 0, fails = 0;
  bit nx_rst = 1'b1, nx_full = 1'b0, nx_redir = 1'b0;
  logic [31:0] nx_rpc = '0;
  bit pend = 1'b0;
  int cnt = 0, lat = 1, we_n = 0, w0 = 0;
  logic [31:0] paddr = '0;

  fetch_unit #(.XLEN(32), .RESET_PC(32'h100)) dut (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .o_imem_req(o_imem_req),
    .o_imem_addr(o_imem_addr),
    .i_imem_ack(i_imem_ack),
    .i_imem_rdata(i_imem_rdata),
    .o_data(o_data),
    .o_we(o_we),
    .i_full(i_full),
    .i_redirect(i_redirect),
    .i_redirect_pc(i_redirect_pc)
`ifdef FETCH_MISALIGN_EN
    ,
    .o_misalign(o_misalign)
`endif
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: apply queued inputs plus the memory response, then sample.
  task automatic step;
    @(posedge i_clk);
    #1;
    i_rst = nx_rst;
    i_full = nx_full;
    i_redirect = nx_redir;
    i_redirect_pc = nx_rpc;
    i_imem_ack = 1'b0;
    i_imem_rdata = '0;
    if (nx_rst) pend = 1'b0;
    else if (pend) begin
      cnt--;
      if (cnt == 0) begin
        i_imem_ack = 1'b1;
        i_imem_rdata = paddr ^ 32'hDEAD0000;
        pend = 1'b0;
      end
    end
    #1;
    if (o_imem_req && !i_rst) begin
      pend = 1'b1;
      cnt = lat;
      paddr = o_imem_addr;
    end
    if (o_we) we_n++;
  endtask

  initial begin
    step;
    chk("rst_req", 64'(o_imem_req), 64'd0);
    chk("rst_we", 64'(o_we), 64'd0);
    chk("rst_data", o_data, 64'd0);
    nx_rst = 1'b0;
    step;
    chk("idle_req", 64'(o_imem_req), 64'd0);
    step;
    chk("first_req", 64'(o_imem_req), 64'd1);
    chk("first_addr", 64'(o_imem_addr), 64'h100);
    step;
    chk("wait_we", 64'(o_we), 64'd0);
    step;
    chk("push_we", 64'(o_we), 64'd1);
    chk("push_data", o_data, {32'h100, 32'hDEAD0100});
    step;
    chk("second_addr", 64'(o_imem_addr), 64'h104);
    step;
    nx_full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step;
      chk("full_we", 64'(o_we), 64'd0);
      chk("full_data", o_data, {32'h104, 32'hDEAD0104});
    end
    nx_full = 1'b0;
    w0 = we_n;
    step;
    chk("release_we", 64'(o_we), 64'd1);
    chk("release_data", o_data, {32'h104, 32'hDEAD0104});
    lat = 3;
    step;
    chk("third_addr", 64'(o_imem_addr), 64'h108);
    chk("one_write", 64'(we_n - w0), 64'd1);
    nx_redir = 1'b1;
    nx_rpc = 32'h200;
    step;
    chk("rd_wait_we", 64'(o_we), 64'd0);
    nx_redir = 1'b0;
    step;
    chk("drop_req", 64'(o_imem_req), 64'd0);
    step;
    chk("drop_ack_we", 64'(o_we), 64'd0);
    lat = 1;
    step;
    chk("rd200_req", 64'(o_imem_req), 64'd1);
    chk("rd200_addr", 64'(o_imem_addr), 64'h200);
    chk("stale_dropped", 64'(we_n - w0), 64'd1);
    nx_redir = 1'b1;
    nx_rpc = 32'h300;
    step;
    chk("rd_ack_we", 64'(o_we), 64'd0);
    nx_redir = 1'b0;
    step;
    chk("rd300_addr", 64'(o_imem_addr), 64'h300);
    chk("rd300_req", 64'(o_imem_req), 64'd1);
    chk("ack_dropped", 64'(we_n - w0), 64'd1);
    step;
    nx_redir = 1'b1;
    nx_rpc = 32'h400;
    step;
    chk("rd_push_we", 64'(o_we), 64'd0);
    nx_redir = 1'b0;
    step;
    chk("rd400_addr", 64'(o_imem_addr), 64'h400);
    step;
    step;
    chk("rd400_we", 64'(o_we), 64'd1);
    chk("rd400_data", o_data, {32'h400, 32'hDEAD0400});
    nx_redir = 1'b1;
    nx_rpc = 32'hFFFF_FFFC;
    step;
    chk("req_rd_addr", 64'(o_imem_addr), 64'h404);
    nx_redir = 1'b0;
    step;
    chk("req_rd_drop_we", 64'(o_we), 64'd0);
    step;
    chk("top_addr", 64'(o_imem_addr), 64'hFFFF_FFFC);
    step;
    step;
    chk("top_data", o_data, {32'hFFFF_FFFC, 32'h2152_FFFC});
    step;
    chk("wrap_addr", 64'(o_imem_addr), 64'h0);
`ifdef FETCH_MISALIGN_EN
    nx_redir = 1'b1;
    nx_rpc = 32'h202;
    step;
    nx_redir = 1'b0;
    step;
    chk("mis_pulse", 64'(o_misalign), 64'd1);
    chk("mis_req", 64'(o_imem_req), 64'd0);
    for (int i = 0; i < 4; i++) begin
      step;
      chk("mis_low", 64'(o_misalign), 64'd0);
      chk("parked_req", 64'(o_imem_req), 64'd0);
    end
    nx_redir = 1'b1;
    nx_rpc = 32'h208;
    step;
    nx_redir = 1'b0;
    step;
    chk("rd208_req", 64'(o_imem_req), 64'd1);
    chk("rd208_addr", 64'(o_imem_addr), 64'h208);
`else
    nx_redir = 1'b1;
    nx_rpc = 32'h502;
    step;
    nx_redir = 1'b0;
    step;
    chk("mask_req", 64'(o_imem_req), 64'd1);
    chk("mask_addr", 64'(o_imem_addr), 64'h500);
`endif
    nx_rst = 1'b1;
    step;
    step;
    chk("midrst_req", 64'(o_imem_req), 64'd0);
    chk("midrst_we", 64'(o_we), 64'd0);
    chk("midrst_data", o_data, 64'd0);
`ifdef FETCH_MISALIGN_EN
    chk("midrst_mis", 64'(o_misalign), 64'd0);
`endif
    nx_rst = 1'b0;
    step;
    step;
    chk("restart_req", 64'(o_imem_req), 64'd1);
    chk("restart_addr", 64'(o_imem_addr), 64'h100);
    $display("== %0d vectors applied, %0d miscompares ==", vec, fails);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning the PC and instruction word width.
REQ-002 SHALL have parameter RESET_PC, default 0, meaning the PC value loaded on reset.
REQ-003 SHALL have port i_clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port i_rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port o_imem_req, output, 1 bit: instruction memory request strobe.
REQ-006 SHALL have port o_imem_addr, output, XLEN: request address.
REQ-007 SHALL have port i_imem_ack, input, 1 bit: response valid, arriving 1 or more cycles after the request.
REQ-008 SHALL have port i_imem_rdata, input, XLEN: instruction word, valid with i_imem_ack.
REQ-009 SHALL have port o_data, output, 2*XLEN: {pc, instr} toward the instruction ring buffer.
REQ-010 SHALL have port o_we, output, 1 bit: write strobe into the ring buffer.
REQ-011 SHALL have port i_full, input, 1 bit: the ring buffer cannot accept a write this cycle.
REQ-012 SHALL have port i_redirect, input, 1 bit: redirect request (branch or flush).
REQ-013 SHALL have port i_redirect_pc, input, XLEN: redirect target.

Function
REQ-014 SHALL implement the FSM states IDLE, REQ, WAIT, PUSH and DROP, with at most one outstanding memory request.
REQ-015 SHALL make the transition IDLE->REQ unconditionally on the first cycle out of reset.
REQ-016 SHALL, in REQ, assert o_imem_req=1 with o_imem_addr=pc, then go to WAIT.
REQ-017 SHALL, in WAIT with i_imem_ack=1, capture i_imem_rdata into a hold register and go to PUSH; without an ack it stays in WAIT.
REQ-018 SHALL, in PUSH with i_full=0, drive o_we=1 and o_data={pc, hold}, set pc<=pc+XLEN/8 (wrapping modulo 2^XLEN), then go to REQ.
REQ-019 SHALL, in PUSH with i_full=1, keep o_we=0 and hold o_data and state stable.
REQ-020 SHALL give a minimum of 3 cycles request-to-request, with a 1-cycle ack.
REQ-021 SHALL, when i_redirect=1, load pc<=i_redirect_pc in every state; redirect has priority over push.
REQ-022 SHALL handle redirect by state:
- IDLE: go to REQ.
- REQ: go to DROP, because the issued request belongs to the old PC.
- WAIT without ack: go to DROP.
- WAIT with ack: discard the data and go to REQ.
- PUSH: force o_we=0, discard the held word and go to REQ.
- DROP: stay in DROP.
REQ-023 SHALL, in DROP, discard the response on i_imem_ack and go to REQ, never writing it to the ring buffer.
REQ-024 SHALL ignore i_imem_ack outside WAIT and DROP.
REQ-025 SHALL keep o_imem_req=0 and o_we=0 in every state not listed as asserting them.

Reset
REQ-026 SHALL, while i_rst=1, set pc=RESET_PC, state=IDLE, o_imem_req=0, o_we=0 and o_data=0.
REQ-027 SHALL let reset asserted mid-operation abandon any outstanding request; memory is reset by the same i_rst.

Configuration
REQ-028 SHALL, with macro FETCH_MISALIGN_EN defined, add output o_misalign (1 bit), reset to 0.
REQ-029 SHALL, with FETCH_MISALIGN_EN defined, treat a redirect target with pc[1:0]!=0 as follows:
- pulse o_misalign=1 for exactly one cycle;
- enter IDLE and issue no requests;
- leave IDLE only on a later aligned redirect.
REQ-030 SHALL, without FETCH_MISALIGN_EN, omit o_misalign and force the loaded redirect target bits [1:0] to 0.

Structure
REQ-031 SHALL place the FSM state enum typedef, the instruction width constant and the PC increment constant in shared package fetch_pkg.
REQ-032 SHALL contain one sub-module, fetch_pc, holding the next-PC mux (increment/redirect/reset) and the PC register.

Verification
REQ-033 SHALL cover reset release with RESET_PC=0x100 and 1-cycle ack: expect o_imem_addr=0x100, then o_we with o_data={0x100, rdata}, then the next request at 0x104.
REQ-034 SHALL cover i_full=1 for 5 cycles in PUSH: expect o_we held low and o_data stable, and exactly one write on release.
REQ-035 SHALL cover redirect to 0x200 in WAIT with a 3-cycle ack: expect the stale word dropped, no o_we, and the next request at 0x200.
REQ-036 SHALL cover redirect to 0x300 coinciding with ack: expect no write and the next request at 0x300.
REQ-037 SHALL cover redirect to 0x400 in PUSH with i_full=0: expect o_we=0 that cycle and the first write {0x400, x}.
REQ-038 SHALL cover, with FETCH_MISALIGN_EN, redirect to 0x202: expect a single o_misalign pulse and no requests until a redirect to 0x208.
